bfm_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single `bfm` adder datapath between two operand requesters, issues a programmed number of transactions, and routes each result back to its originator. It sits between the stimulus sources (DPI-fed byte streams or test sequences) and the `bfm` instance, replacing the fixed pointer/LENGTH driver loop with a start/len/done control interface.

---
 rtl/bfm_arbiter_pkg.sv | 15 +
 rtl/bfm_arbiter_if.sv | 42 ++++
 rtl/bfm_arbiter_tag_pipe.sv | 33 +++
 rtl/bfm_arbiter.sv | 139 +++++++++++++
 tb/tb_bfm_arbiter.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bfm_arbiter_pkg.sv
// Shared types for the bfm_arbiter slice: FSM states and requester id.
package bfm_arb_pkg;

  localparam int unsigned NUM_REQ = 2;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } arb_state_e;

  typedef logic req_id_t;

endpackage

// File: rtl/bfm_arbiter_if.sv
// Control, requester, datapath and response signals of bfm_arbiter.
interface bfm_arbiter_if #(
  parameter int unsigned DW    = 8,
  parameter int unsigned LEN_W = 16
) ();

  logic             start_i;
  logic [LEN_W-1:0] len_i;
  logic             busy_o;
  logic             done_o;
  logic [LEN_W-1:0] issued_cnt_o;
  logic             req0_valid_i;
  logic             req1_valid_i;
  logic [DW-1:0]    req0_a_i;
  logic [DW-1:0]    req0_b_i;
  logic [DW-1:0]    req1_a_i;
  logic [DW-1:0]    req1_b_i;
  logic             req0_ready_o;
  logic             req1_ready_o;
  logic             dp_valid_o;
  logic [DW-1:0]    dp_a_o;
  logic [DW-1:0]    dp_b_o;
  logic [DW-1:0]    dp_res_i;
  logic             rsp0_valid_o;
  logic             rsp1_valid_o;
  logic [DW-1:0]    rsp_data_o;

  modport slave (
    input  start_i, len_i, req0_valid_i, req1_valid_i,
    input  req0_a_i, req0_b_i, req1_a_i, req1_b_i, dp_res_i,
    output busy_o, done_o, issued_cnt_o, req0_ready_o, req1_ready_o,
    output dp_valid_o, dp_a_o, dp_b_o, rsp0_valid_o, rsp1_valid_o, rsp_data_o
  );

  modport master (
    output start_i, len_i, req0_valid_i, req1_valid_i,
    output req0_a_i, req0_b_i, req1_a_i, req1_b_i, dp_res_i,
    input  busy_o, done_o, issued_cnt_o, req0_ready_o, req1_ready_o,
    input  dp_valid_o, dp_a_o, dp_b_o, rsp0_valid_o, rsp1_valid_o, rsp_data_o
  );

endinterface

// File: rtl/bfm_arbiter_tag_pipe.sv
// Shift register of {valid, id} tags that tracks transactions through the datapath.
module tag_pipe
  import bfm_arb_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic    clk_i,
  input  logic    reset_i,
  input  logic    valid_i,
  input  req_id_t id_i,
  output logic    valid_o,
  output req_id_t id_o,
  output logic    empty_o
);

  logic [Depth-1:0] r_valid;
  logic [Depth-1:0] r_id;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_valid <= '0;
      r_id    <= '0;
    end else begin
      r_valid <= {r_valid[Depth-2:0], valid_i};
      r_id    <= {r_id[Depth-2:0], id_i};
    end
  end

  assign valid_o = r_valid[Depth-1];
  assign id_o    = r_id[Depth-1];
  assign empty_o = ~|r_valid;

endmodule

// File: rtl/bfm_arbiter.sv
// Round-robin sequencer sharing one bfm datapath between two requesters,
// issuing a programmed number of transactions and routing results back.
module bfm_arbiter
  import bfm_arb_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned LAT   = 1,
  parameter int unsigned LEN_W = 16
) (
  input logic           clk_i,
  input logic           reset_i,
  bfm_arbiter_if.slave  bus
);

  arb_state_e       r_state;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_issued;
  logic             r_busy;
  logic             r_done;
  req_id_t          r_last;
  logic             r_dp_valid;
  logic [DW-1:0]    r_dp_a;
  logic [DW-1:0]    r_dp_b;
  logic             r_rsp0;
  logic             r_rsp1;
  logic [DW-1:0]    r_rsp_data;

  logic    w_can;
  logic    w_gnt0;
  logic    w_gnt1;
  logic    w_xfer;
  req_id_t w_xfer_id;
  logic    w_tail_valid;
  req_id_t w_tail_id;
  logic    w_empty;

  // r_last holds the id granted most recently; the other one wins a tie.
  assign w_can     = (r_state == StRun) && (r_issued < r_len);
  assign w_gnt0    = w_can && bus.req0_valid_i && (!bus.req1_valid_i || (r_last == 1'b1));
  assign w_gnt1    = w_can && bus.req1_valid_i && (!bus.req0_valid_i || (r_last == 1'b0));
  assign w_xfer    = w_gnt0 | w_gnt1;
  assign w_xfer_id = w_gnt1;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state  <= StIdle;
      r_len    <= '0;
      r_issued <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (bus.start_i) begin
            r_len    <= bus.len_i;
            r_issued <= '0;
            if (bus.len_i == '0) begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end else begin
              r_state <= StRun;
              r_busy  <= 1'b1;
            end
          end
        end
        StRun: begin
          if (w_xfer) begin
            r_issued <= r_issued + 1'b1;
            if ((r_issued + 1'b1) == r_len) r_state <= StDrain;
          end
        end
        // Empty here means the last tag left the pipe and its response is out now.
        StDrain: begin
          if (w_empty) begin
            r_state <= StDone;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_last <= 1'b1;
    end else if (w_xfer) begin
      r_last <= w_xfer_id;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_dp_valid <= 1'b0;
      r_dp_a     <= '0;
      r_dp_b     <= '0;
      r_rsp0     <= 1'b0;
      r_rsp1     <= 1'b0;
      r_rsp_data <= '0;
    end else begin
      r_dp_valid <= w_xfer;
      if (w_xfer) begin
        r_dp_a <= w_gnt1 ? bus.req1_a_i : bus.req0_a_i;
        r_dp_b <= w_gnt1 ? bus.req1_b_i : bus.req0_b_i;
      end
      r_rsp0 <= w_tail_valid && (w_tail_id == 1'b0);
      r_rsp1 <= w_tail_valid && (w_tail_id == 1'b1);
      if (w_tail_valid) r_rsp_data <= bus.dp_res_i;
    end
  end

  tag_pipe #(
    .Depth (LAT + 1)
  ) u_tag_pipe (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .valid_i (w_xfer),
    .id_i    (w_xfer_id),
    .valid_o (w_tail_valid),
    .id_o    (w_tail_id),
    .empty_o (w_empty)
  );

  assign bus.busy_o       = r_busy;
  assign bus.done_o       = r_done;
  assign bus.issued_cnt_o = r_issued;
  assign bus.req0_ready_o = w_gnt0;
  assign bus.req1_ready_o = w_gnt1;
  assign bus.dp_valid_o   = r_dp_valid;
  assign bus.dp_a_o       = r_dp_a;
  assign bus.dp_b_o       = r_dp_b;
  assign bus.rsp0_valid_o = r_rsp0;
  assign bus.rsp1_valid_o = r_rsp1;
  assign bus.rsp_data_o   = r_rsp_data;

endmodule

// File: tb/tb_bfm_arbiter.sv
// Directed bench for bfm_arbiter: a LAT=1 and a LAT=4 instance, each fed by an adder
// model, with a scoreboard matching every handshake to its response.
module tb_bfm_arbiter;

  typedef struct {
    int         cyc;
    logic       id;
    logic [7:0] data;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  sb_t  q1[$];
  sb_t  q4[$];
  int   glog[$];
  int   rlog[$];
  int   n_rsp0[2] = '{0, 0};
  int   n_rsp1[2] = '{0, 0};
  int   n_done[2] = '{0, 0};
  int   n_dpv[2] = '{0, 0};
  int   last_rsp_cyc[2] = '{0, 0};
  int   first_rsp_cyc[2] = '{-1, -1};
  logic last_rsp_busy[2];

  bfm_arbiter_if #(.DW(8), .LEN_W(16)) if1 ();
  bfm_arbiter_if #(.DW(8), .LEN_W(16)) if4 ();

  bfm_arbiter #(.DW(8), .LAT(1), .LEN_W(16)) u_dut1 (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (if1)
  );

  bfm_arbiter #(.DW(8), .LAT(4), .LEN_W(16)) u_dut4 (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (if4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Adder datapath models with 1 and 4 cycles of latency.
  logic [7:0] res1;
  logic [7:0] p4[4];
  always @(posedge clk) begin
    res1  <= if1.dp_a_o + if1.dp_b_o;
    p4[0] <= if4.dp_a_o + if4.dp_b_o;
    for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
  end
  assign if1.dp_res_i = res1;
  assign if4.dp_res_i = p4[3];

  logic       hs0_w[2], hs1_w[2], rsp0_w[2], rsp1_w[2], done_w[2], busy_w[2], dpv_w[2];
  logic [7:0] sum0_w[2], sum1_w[2], rdata_w[2];
  assign hs0_w[0]   = if1.req0_valid_i & if1.req0_ready_o;
  assign hs1_w[0]   = if1.req1_valid_i & if1.req1_ready_o;
  assign rsp0_w[0]  = if1.rsp0_valid_o;
  assign rsp1_w[0]  = if1.rsp1_valid_o;
  assign done_w[0]  = if1.done_o;
  assign busy_w[0]  = if1.busy_o;
  assign dpv_w[0]   = if1.dp_valid_o;
  assign sum0_w[0]  = if1.req0_a_i + if1.req0_b_i;
  assign sum1_w[0]  = if1.req1_a_i + if1.req1_b_i;
  assign rdata_w[0] = if1.rsp_data_o;
  assign hs0_w[1]   = if4.req0_valid_i & if4.req0_ready_o;
  assign hs1_w[1]   = if4.req1_valid_i & if4.req1_ready_o;
  assign rsp0_w[1]  = if4.rsp0_valid_o;
  assign rsp1_w[1]  = if4.rsp1_valid_o;
  assign done_w[1]  = if4.done_o;
  assign busy_w[1]  = if4.busy_o;
  assign dpv_w[1]   = if4.dp_valid_o;
  assign sum0_w[1]  = if4.req0_a_i + if4.req0_b_i;
  assign sum1_w[1]  = if4.req1_a_i + if4.req1_b_i;
  assign rdata_w[1] = if4.rsp_data_o;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: push on handshake, pop and compare on response.
  always @(negedge clk) begin
    if (rst) begin
      q1.delete();
      q4.delete();
    end else begin
      for (int k = 0; k < 2; k++) begin
        sb_t e;
        bit  have;
        if (rsp0_w[k] || rsp1_w[k]) begin
          chk("rsp_one_hot", {31'd0, rsp0_w[k] & rsp1_w[k]}, 0);
          have = (k == 0) ? (q1.size() != 0) : (q4.size() != 0);
          chk("rsp_expected", {31'd0, have}, 1);
          if (have) begin
            if (k == 0) e = q1.pop_front();
            else        e = q4.pop_front();
            chk("rsp_id", {31'd0, rsp1_w[k]}, {31'd0, e.id});
            chk("rsp_data", {24'd0, rdata_w[k]}, {24'd0, e.data});
            chk("rsp_latency", cyc - e.cyc, (k == 0) ? 3 : 6);
          end
          if (rsp1_w[k]) n_rsp1[k]++;
          else           n_rsp0[k]++;
          if (k == 0) rlog.push_back(int'(rdata_w[k]));
          last_rsp_cyc[k]  = cyc;
          last_rsp_busy[k] = busy_w[k];
          if (first_rsp_cyc[k] < 0) first_rsp_cyc[k] = cyc;
        end
        if (hs0_w[k] && hs1_w[k]) chk("one_grant", 2, 1);
        if (hs0_w[k] || hs1_w[k]) begin
          e.cyc  = cyc;
          e.id   = hs1_w[k];
          e.data = hs1_w[k] ? sum1_w[k] : sum0_w[k];
          if (k == 0) begin
            q1.push_back(e);
            glog.push_back(hs1_w[k] ? 1 : 0);
          end else begin
            q4.push_back(e);
          end
        end
        if (done_w[k]) n_done[k]++;
        if (dpv_w[k])  n_dpv[k]++;
      end
    end
  end

  task automatic start_run(input int k, input logic [15:0] len);
    @(posedge clk); #1;
    if (k == 0) begin if1.start_i = 1'b1; if1.len_i = len; end
    else        begin if4.start_i = 1'b1; if4.len_i = len; end
    @(posedge clk); #1;
    if1.start_i = 1'b0;
    if4.start_i = 1'b0;
  endtask

  task automatic wait_done(input int k, input int budget);
    bit seen = 1'b0;
    int dc = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done_w[k]) begin
        seen = 1'b1;
        dc   = cyc;
      end
    end
    chk("done_seen", {31'd0, seen}, 1);
    if (seen) chk("done_after_last_rsp", dc - last_rsp_cyc[k], 1);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done_w[k]}, 0);
    chk("idle_after_done", {31'd0, busy_w[k]}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int r0, r1, dn, dv;
    {if1.start_i, if1.req0_valid_i, if1.req1_valid_i} = '0;
    {if4.start_i, if4.req0_valid_i, if4.req1_valid_i} = '0;
    if1.len_i = '0; if4.len_i = '0;
    {if1.req0_a_i, if1.req0_b_i, if1.req1_a_i, if1.req1_b_i} = '0;
    {if4.req0_a_i, if4.req0_b_i, if4.req1_a_i, if4.req1_b_i} = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, if1.busy_o}, 0);
    chk("rst_done", {31'd0, if1.done_o}, 0);
    chk("rst_issued", {16'd0, if1.issued_cnt_o}, 0);
    chk("rst_dp_valid", {31'd0, if1.dp_valid_o}, 0);
    chk("rst_rsp", {30'd0, if1.rsp0_valid_o, if1.rsp1_valid_o}, 0);
    chk("rst_rsp_data", {24'd0, if4.rsp_data_o}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Contention: grants and responses alternate starting with req0
    if1.req0_valid_i = 1'b1; if1.req0_a_i = 8'd1;  if1.req0_b_i = 8'd2;
    if1.req1_valid_i = 1'b1; if1.req1_a_i = 8'd10; if1.req1_b_i = 8'd20;
    start_run(0, 16'd6);
    wait_done(0, 50);
    if1.req1_valid_i = 1'b0;
    chk("grant_count", glog.size(), 6);
    for (int i = 0; i < glog.size() && i < 6; i++) chk("grant_order", glog[i], i % 2);
    chk("rsp_count", rlog.size(), 6);
    for (int i = 0; i < rlog.size() && i < 6; i++)
      chk("rsp_order", rlog[i], (i % 2 == 1) ? 30 : 3);
    chk("contention_issued", {16'd0, if1.issued_cnt_o}, 6);

    // Single requester, len=4
    r0 = n_rsp0[0]; r1 = n_rsp1[0];
    start_run(0, 16'd4);
    wait_done(0, 50);
    if1.req0_valid_i = 1'b0;
    chk("single_rsp0", n_rsp0[0] - r0, 4);
    chk("single_rsp1", n_rsp1[0] - r1, 0);
    chk("single_issued", {16'd0, if1.issued_cnt_o}, 4);
    chk("hold_rsp_data", {24'd0, if1.rsp_data_o}, 3);
    chk("hold_dp_a", {24'd0, if1.dp_a_o}, 1);

    // Zero length: straight to DONE, no issue, never busy
    dv = n_dpv[0];
    start_run(0, 16'd0);
    @(negedge clk);
    chk("zero_done", {31'd0, if1.done_o}, 1);
    chk("zero_busy", {31'd0, if1.busy_o}, 0);
    @(negedge clk);
    chk("zero_done_pulse", {31'd0, if1.done_o}, 0);
    chk("zero_busy2", {31'd0, if1.busy_o}, 0);
    chk("zero_dp_valid", n_dpv[0] - dv, 0);
    chk("zero_issued", {16'd0, if1.issued_cnt_o}, 0);

    // Start ignored while busy
    r0 = n_rsp0[0];
    if1.req0_valid_i = 1'b1;
    start_run(0, 16'd2);
    if1.start_i = 1'b1; if1.len_i = 16'd9;
    @(posedge clk); #1;
    if1.start_i = 1'b0;
    wait_done(0, 50);
    if1.req0_valid_i = 1'b0;
    chk("ignore_issued", {16'd0, if1.issued_cnt_o}, 2);
    chk("ignore_rsp", n_rsp0[0] - r0, 2);
    repeat (3) @(posedge clk); #1;
    chk("ignore_no_restart", {31'd0, if1.busy_o}, 0);

    // Reset with transactions in flight
    if1.req0_a_i = 8'd4; if1.req0_b_i = 8'd5;
    if1.req0_valid_i = 1'b1;
    start_run(0, 16'd8);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_issued", {16'd0, if1.issued_cnt_o}, 2);
    rst = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, if1.busy_o}, 0);
    chk("midrst_dp_valid", {31'd0, if1.dp_valid_o}, 0);
    chk("midrst_issued", {16'd0, if1.issued_cnt_o}, 0);
    chk("midrst_ready", {31'd0, if1.req0_ready_o}, 0);
    if1.req0_valid_i = 1'b0;
    r0 = n_rsp0[0]; dn = n_done[0];
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) @(posedge clk); #1;
    chk("midrst_no_rsp", n_rsp0[0] - r0, 0);
    chk("midrst_no_done", n_done[0] - dn, 0);
    if1.req0_valid_i = 1'b1;
    start_run(0, 16'd1);
    wait_done(0, 50);
    if1.req0_valid_i = 1'b0;
    chk("after_rst_rsp", n_rsp0[0] - r0, 1);
    chk("after_rst_issued", {16'd0, if1.issued_cnt_o}, 1);
    chk("after_rst_data", {24'd0, if1.rsp_data_o}, 9);

    // LAT=4, len=3 back-to-back
    if4.req0_a_i = 8'd5; if4.req0_b_i = 8'd7;
    if4.req0_valid_i = 1'b1;
    start_run(1, 16'd3);
    wait_done(1, 60);
    if4.req0_valid_i = 1'b0;
    chk("lat4_rsp", n_rsp0[1], 3);
    chk("lat4_consecutive", last_rsp_cyc[1] - first_rsp_cyc[1], 2);
    chk("lat4_drain_busy", {31'd0, last_rsp_busy[1]}, 1);
    chk("lat4_data", {24'd0, if4.rsp_data_o}, 12);
    chk("lat4_issued", {16'd0, if4.issued_cnt_o}, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
